// File: rtl/pwm_serial_gen.sv
// pwm_serial_gen: multi-channel PWM generator with a shared period counter.
//
// Each channel has a run-time programmable duty. Writes go to a pending
// array, which is copied into the active array when the period wraps, so a
// channel's duty never changes part way through a period. Compare bits are
// evaluated one channel per cycle, shifted into an internal register, and
// the complete NUM_CH-bit word is latched onto pwm once per scan frame. The
// same serial bit and latch strobe are exported to drive an external
// shift-register chain.
//
// Build option:
//   PWM_POLARITY_EN - adds a per-channel polarity input that inverts the
//                     compare bit while running (idle outputs stay 0).
//
// Ports:
//   clk           clock
//   reset         asynchronous, active-high reset
//   enable        run when high; low forces the scan/counter idle
//   period        terminal count, sampled only when the counter wraps
//   wr_en         single-cycle duty write strobe
//   wr_ch         channel index of the write (out-of-range ignored)
//   wr_duty       duty value; channel is high while cnt < duty
//   polarity      per-channel output inversion (PWM_POLARITY_EN only)
//   pwm           latched parallel PWM word, bit k = channel k
//   ser_data      compare bit evaluated this cycle
//   ser_latch     one-cycle pulse in the cycle pwm updates
//   period_start  one-cycle pulse in the cycle after the counter wraps
module pwm_serial_gen #(
  parameter int NUM_CH     = 8,
  parameter int CNT_W      = 8,
  parameter int PERIOD_RST = 99
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [CNT_W-1:0]           period,
  input  logic                       wr_en,
  input  logic [$clog2(NUM_CH)-1:0]  wr_ch,
  input  logic [CNT_W-1:0]           wr_duty,
`ifdef PWM_POLARITY_EN
  input  logic [NUM_CH-1:0]          polarity,
`endif
  output logic [NUM_CH-1:0]          pwm,
  output logic                       ser_data,
  output logic                       ser_latch,
  output logic                       period_start
);

  localparam int IDX_W = $clog2(NUM_CH);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  per_q, per_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NUM_CH-1:0] shift_q, shift_d;
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic              ser_data_q, ser_data_d;
  logic              ser_latch_q, ser_latch_d;
  logic              period_start_q, period_start_d;
  logic [CNT_W-1:0]  pend_q [NUM_CH];
  logic [CNT_W-1:0]  pend_d [NUM_CH];
  logic [CNT_W-1:0]  act_q  [NUM_CH];
  logic [CNT_W-1:0]  act_d  [NUM_CH];

  logic wrap;
  logic last_ch;
  logic cmp_bit;

  always_comb begin
    wrap    = enable && (cnt_q == per_q);
    last_ch = (idx_q == IDX_W'(NUM_CH - 1));
    cmp_bit = (cnt_q < act_q[idx_q]);
`ifdef PWM_POLARITY_EN
    cmp_bit = cmp_bit ^ polarity[idx_q];
`endif
  end

  always_comb begin
    cnt_d          = cnt_q;
    per_d          = per_q;
    idx_d          = idx_q;
    shift_d        = shift_q;
    pwm_d          = pwm_q;
    ser_data_d     = ser_data_q;
    ser_latch_d    = ser_latch_q;
    period_start_d = period_start_q;
    act_d          = act_q;
    pend_d         = pend_q;

    // Matching by loop index means out-of-range channel numbers never hit.
    for (int k = 0; k < NUM_CH; k++) begin
      if (wr_en && (wr_ch == IDX_W'(k))) begin
        pend_d[k] = wr_duty;
      end
    end

    if (enable) begin
      ser_data_d  = cmp_bit;
      shift_d     = {cmp_bit, shift_q[NUM_CH-1:1]};
      idx_d       = last_ch ? '0 : idx_q + IDX_W'(1);
      // Latch the frame including this cycle's bit, so no extra cycle is lost.
      pwm_d       = last_ch ? {cmp_bit, shift_q[NUM_CH-1:1]} : pwm_q;
      ser_latch_d = last_ch;
      period_start_d = wrap;
      if (wrap) begin
        cnt_d = '0;
        act_d = pend_q;  // pre-write pending: a same-edge write waits a period
        per_d = period;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d          = '0;
      idx_d          = '0;
      shift_d        = '0;
      pwm_d          = '0;
      ser_data_d     = 1'b0;
      ser_latch_d    = 1'b0;
      period_start_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q          <= '0;
      per_q          <= CNT_W'(PERIOD_RST);
      idx_q          <= '0;
      shift_q        <= '0;
      pwm_q          <= '0;
      ser_data_q     <= 1'b0;
      ser_latch_q    <= 1'b0;
      period_start_q <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        pend_q[k] <= '0;
        act_q[k]  <= '0;
      end
    end else begin
      cnt_q          <= cnt_d;
      per_q          <= per_d;
      idx_q          <= idx_d;
      shift_q        <= shift_d;
      pwm_q          <= pwm_d;
      ser_data_q     <= ser_data_d;
      ser_latch_q    <= ser_latch_d;
      period_start_q <= period_start_d;
      pend_q         <= pend_d;
      act_q          <= act_d;
    end
  end

  assign pwm          = pwm_q;
  assign ser_data     = ser_data_q;
  assign ser_latch    = ser_latch_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_serial_gen.sv
// tb_pwm_serial_gen: self-checking bench for pwm_serial_gen.
//
// A behavioural model tracks the counter, pending/active duties and frame
// position as plain integers; each frame it collects one compare bit per
// channel into an array and publishes the word at the end of the frame.
// Directed phases cover reset, duty limits, shadowing, period changes and
// enable toggling; a randomized phase follows.
module tb_pwm_serial_gen;

  localparam int NUM_CH     = 8;
  localparam int CNT_W      = 8;
  localparam int PERIOD_RST = 99;
  localparam int IDX_W      = $clog2(NUM_CH);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic [CNT_W-1:0]  period = CNT_W'(99);
  logic              wr_en = 1'b0;
  logic [IDX_W-1:0]  wr_ch = '0;
  logic [CNT_W-1:0]  wr_duty = '0;
  logic [NUM_CH-1:0] pwm;
  logic              ser_data;
  logic              ser_latch;
  logic              period_start;
`ifdef PWM_POLARITY_EN
  logic [NUM_CH-1:0] polarity = '0;
`endif

  pwm_serial_gen #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PERIOD_RST(PERIOD_RST)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .period(period),
    .wr_en(wr_en),
    .wr_ch(wr_ch),
    .wr_duty(wr_duty),
`ifdef PWM_POLARITY_EN
    .polarity(polarity),
`endif
    .pwm(pwm),
    .ser_data(ser_data),
    .ser_latch(ser_latch),
    .period_start(period_start)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int                m_cnt, m_per, m_pos;
  int                m_pend [NUM_CH];
  int                m_act  [NUM_CH];
  logic [NUM_CH-1:0] m_bits, m_pwm;
  logic              m_ser, m_latch, m_ps;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_cnt = 0; m_per = PERIOD_RST; m_pos = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      m_pend[k] = 0;
      m_act[k]  = 0;
    end
    m_bits = '0; m_pwm = '0; m_ser = 1'b0; m_latch = 1'b0; m_ps = 1'b0;
  endfunction

  function automatic void model_edge();
    int   old_pend [NUM_CH];
    logic b;
    old_pend = m_pend;
    if (wr_en && int'(wr_ch) < NUM_CH) m_pend[int'(wr_ch)] = int'(wr_duty);
    if (enable) begin
      b = (m_cnt < m_act[m_pos]);
`ifdef PWM_POLARITY_EN
      b = b ^ polarity[m_pos];
`endif
      m_bits[m_pos] = b;
      m_ser   = b;
      m_latch = (m_pos == NUM_CH - 1);
      if (m_latch) m_pwm = m_bits;
      m_pos = (m_pos + 1) % NUM_CH;
      m_ps  = (m_cnt == m_per);
      if (m_ps) begin
        m_cnt = 0;
        m_act = old_pend;
        m_per = int'(period);
      end else begin
        m_cnt++;
      end
    end else begin
      m_cnt = 0; m_pos = 0; m_bits = '0; m_pwm = '0;
      m_ser = 1'b0; m_latch = 1'b0; m_ps = 1'b0;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_val("pwm", pwm, m_pwm);
    check_val("ser_data", ser_data, m_ser);
    check_val("ser_latch", ser_latch, m_latch);
    check_val("period_start", period_start, m_ps);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      wr_en = 1'b0;
    end
  endtask

  task automatic write_duty(input int ch, input int d);
    wr_ch   = IDX_W'(ch);
    wr_duty = CNT_W'(d);
    wr_en   = 1'b1;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic wait_cnt(input int v);
    int i = 0;
    while (m_cnt != v && i < 400) begin
      step();
      i++;
    end
    if (m_cnt != v) check_val("wait_cnt_timeout", 64'(m_cnt), 64'(v));
  endtask

  task automatic wait_pos(input int v);
    int i = 0;
    while (m_pos != v && i < 40) begin
      step();
      i++;
    end
    if (m_pos != v) check_val("wait_pos_timeout", 64'(m_pos), 64'(v));
  endtask

  // Called at a negedge; reset hits mid-cycle and must clear outputs at once.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_val("rst_pwm", pwm, 0);
    check_val("rst_latch", ser_latch, 0);
    check_val("rst_pstart", period_start, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi [NUM_CH];
    int last;
    int n;
    int d;

    model_reset();
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    enable = 1'b1;

    // Reset mid-frame, then all duties are zero: pwm stays low.
    run(13);
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      step();
      check_val("idle_pwm", pwm, 0);
    end

    // Duty limits: 0 -> constant low, > period -> constant high.
    write_duty(0, 0);
    write_duty(7, 100);
    run(120);
    last = -1;
    for (int i = 0; i < 200; i++) begin
      step();
      check_val("duty0_low", pwm[0], 1'b0);
      check_val("duty_max_high", pwm[7], 1'b1);
      if (ser_latch) begin
        if (last >= 0) check_val("latch_gap", 64'(i - last), 8);
        last = i;
      end
    end

    // Staircase duties and high-time windows.
    for (int k = 0; k < NUM_CH; k++) write_duty(k, (k + 1) * 10);
    run(300);
    for (int k = 0; k < NUM_CH; k++) hi[k] = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      for (int k = 0; k < NUM_CH; k++) hi[k] += int'(pwm[k]);
    end
    for (int k = 0; k < NUM_CH; k++) begin
      d = hi[k] - (k + 1) * 20;
      check_val($sformatf("hi_time_ch%0d", k), 64'(d <= 8 && d >= -8), 1);
    end
    last = -1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (period_start) begin
        if (last >= 0) check_val("pstart_gap100", 64'(i - last), 100);
        last = i;
      end
    end

    // Shadowing: mid-period write, then a write on the wrap edge itself.
    write_duty(3, 50);
    run(120);
    wait_cnt(20);
    write_duty(3, 90);
    run(150);
    wait_cnt(99);
    write_duty(3, 30);
    run(220);

    // Period change takes effect at the next wrap; period 0 wraps each cycle.
    wait_cnt(50);
    period = CNT_W'(9);
    run(150);
    last = -1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (period_start) begin
        if (last >= 0) check_val("pstart_gap10", 64'(i - last), 10);
        last = i;
      end
    end
    period = CNT_W'(0);
    run(15);
    for (int i = 0; i < 20; i++) begin
      step();
      check_val("p0_pstart", period_start, 1'b1);
    end
    period = CNT_W'(99);
    run(150);

    // Enable toggle mid-frame; re-enable gives first latch after NUM_CH edges.
    wait_pos(4);
    enable = 1'b0;
    step();
    check_val("dis_pwm", pwm, 0);
    run(5);
    enable = 1'b1;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (ser_latch) begin
        n = i;
        break;
      end
    end
    check_val("reen_latch_delay", 64'(n), 8);
    run(250);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_ch   = IDX_W'($urandom);
      wr_duty = CNT_W'($urandom_range(0, 40));
      if ($urandom_range(0, 99) == 0) period = CNT_W'($urandom_range(0, 30));
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      if ($urandom_range(0, 599) == 0) do_reset();
      else step();
    end
    wr_en = 1'b0;
    run(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
